div_s8s8_q8_seq: RTL and testbench

DIV_S8S8_Q8_SEQ -- requirements
Module: div_s8s8_q8_seq

---
 rtl/div_s8s8_q8_seq.sv | 172 +++++++++++++++++
 tb/tb_div_s8s8_q8_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_s8s8_q8_seq.sv
// Sequential signed 8/8 restoring divider with valid/ready handshakes, truncating toward zero.
// Optional DIV0 flag output is built only when DIV_S8S8_Q8_SEQ_DIV0_EN is defined.
module div_s8s8_q8_seq (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CE,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic signed [7:0] A,
  input  logic signed [7:0] B,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic signed [7:0] Q,
  output logic signed [7:0] R
`ifdef DIV_S8S8_Q8_SEQ_DIV0_EN
  ,
  output logic              DIV0
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  dvd_q, dvd_d;     // dividend magnitude, shifts into quotient bits
  logic [7:0]  dvs_q, dvs_d;
  logic [7:0]  rem_q, rem_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        bz_q, bz_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  r_q, r_d;
  logic        m_valid_q, m_valid_d;
`ifdef DIV_S8S8_Q8_SEQ_DIV0_EN
  logic        div0_q, div0_d;
`endif

  logic [8:0]  shifted_s;
  logic [8:0]  diff_s;
  logic        ge_s;
  logic [7:0]  a_mag_s;
  logic [7:0]  b_mag_s;

  assign S_READY = (state_q == IDLE) & CE;
  assign M_VALID = m_valid_q;
  assign Q       = q_q;
  assign R       = r_q;
`ifdef DIV_S8S8_Q8_SEQ_DIV0_EN
  assign DIV0    = div0_q;
`endif

  // Magnitudes (|-128| = 0x80) and one restoring step; partial remainder stays below divisor.
  always_comb begin
    a_mag_s   = A[7] ? (~A + 8'd1) : A;
    b_mag_s   = B[7] ? (~B + 8'd1) : B;
    shifted_s = {rem_q, dvd_q[7]};
    diff_s    = shifted_s - {1'b0, dvs_q};
    ge_s      = (shifted_s >= {1'b0, dvs_q});
  end

  // Next-state and datapath updates; everything holds when CE is low.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    bz_d      = bz_q;
    q_d       = q_q;
    r_d       = r_q;
    m_valid_d = m_valid_q;
`ifdef DIV_S8S8_Q8_SEQ_DIV0_EN
    div0_d    = div0_q;
`endif
    if (CE) begin
      case (state_q)
        IDLE: begin
          if (S_VALID) begin
            dvd_d   = a_mag_s;
            dvs_d   = b_mag_s;
            rem_d   = 8'd0;
            sa_d    = A[7];
            sb_d    = B[7];
            bz_d    = (B == 8'sd0);
            cnt_d   = 3'd0;
            state_d = CALC;
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          rem_d = ge_s ? diff_s[7:0] : shifted_s[7:0];
          dvd_d = {dvd_q[6:0], ge_s};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
        end
        FIX: begin
          // Zero divisor forces all-ones quotient; remainder magnitude already equals |A|.
          if (bz_q) begin
            q_d = 8'hFF;
          end else if (sa_q != sb_q) begin
            q_d = ~dvd_q + 8'd1;
          end else begin
            q_d = dvd_q;
          end
          r_d       = sa_q ? (~rem_q + 8'd1) : rem_q;
          m_valid_d = 1'b1;
`ifdef DIV_S8S8_Q8_SEQ_DIV0_EN
          div0_d    = bz_q;
`endif
          state_d   = DONE;
        end
        DONE: begin
          if (M_READY) begin
            m_valid_d = 1'b0;
            state_d   = IDLE;
          end else begin
            state_d   = DONE;
          end
        end
        default: begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset taking priority over CE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      dvd_q     <= 8'd0;
      dvs_q     <= 8'd0;
      rem_q     <= 8'd0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      bz_q      <= 1'b0;
      q_q       <= 8'd0;
      r_q       <= 8'd0;
      m_valid_q <= 1'b0;
`ifdef DIV_S8S8_Q8_SEQ_DIV0_EN
      div0_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      bz_q      <= bz_d;
      q_q       <= q_d;
      r_q       <= r_d;
      m_valid_q <= m_valid_d;
`ifdef DIV_S8S8_Q8_SEQ_DIV0_EN
      div0_q    <= div0_d;
`endif
    end
  end

endmodule

// File: tb/tb_div_s8s8_q8_seq.sv
// Directed self-checking bench for div_s8s8_q8_seq; DIV0 checks follow DIV_S8S8_Q8_SEQ_DIV0_EN.
module tb_div_s8s8_q8_seq;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              CE;
  logic              S_VALID;
  logic              S_READY;
  logic signed [7:0] A;
  logic signed [7:0] B;
  logic              M_VALID;
  logic              M_READY;
  logic signed [7:0] Q;
  logic signed [7:0] R;
`ifdef DIV_S8S8_Q8_SEQ_DIV0_EN
  logic              DIV0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc;

  div_s8s8_q8_seq dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .CE      (CE),
    .S_VALID (S_VALID),
    .S_READY (S_READY),
    .A       (A),
    .B       (B),
    .M_VALID (M_VALID),
    .M_READY (M_READY),
    .Q       (Q),
    .R       (R)
`ifdef DIV_S8S8_Q8_SEQ_DIV0_EN
    ,
    .DIV0    (DIV0)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Present operands in IDLE and let the next rising edge accept them.
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input string tag);
    @(negedge CLK);
    chk({tag, "_s_ready"}, {7'd0, S_READY}, 8'd1);
    A = a; B = b; S_VALID = 1'b1;
    @(posedge CLK); #1;
    S_VALID = 1'b0; A = 8'h5A; B = 8'hA5;
  endtask

  // Cycle 1 is the cycle right after the accept edge; returns the first cycle with M_VALID high.
  task automatic wait_valid(output int c);
    c = 1;
    while (M_VALID !== 1'b1 && c < 40) begin
      @(posedge CLK); #1;
      c++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                              input logic d0);
    chk({tag, "_m_valid"}, {7'd0, M_VALID}, 8'd1);
    chk({tag, "_q"}, Q, q);
    chk({tag, "_r"}, R, r);
`ifdef DIV_S8S8_Q8_SEQ_DIV0_EN
    chk({tag, "_div0"}, {7'd0, DIV0}, {7'd0, d0});
`else
    if (d0 === 1'bx) $display("unreachable");
`endif
  endtask

  task automatic complete(input string tag);
    @(negedge CLK);
    M_READY = 1'b1;
    @(posedge CLK); #1;
    M_READY = 1'b0;
    chk({tag, "_mv_after"}, {7'd0, M_VALID}, 8'd0);
  endtask

  task automatic full_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                         input logic [7:0] r, input logic d0, input string tag);
    accept(a, b, tag);
    wait_valid(cyc);
    chk({tag, "_latency"}, 8'(cyc), 8'd10);
    check_result(tag, q, r, d0);
    complete(tag);
  endtask

  initial begin
    RESET = 1'b1; CE = 1'b1; S_VALID = 1'b0; A = 8'd0; B = 8'd0; M_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    chk("rst_m_valid", {7'd0, M_VALID}, 8'd0);
    chk("rst_q", Q, 8'h00);
    chk("rst_r", R, 8'h00);
    chk("rst_s_ready", {7'd0, S_READY}, 8'd1);
`ifdef DIV_S8S8_Q8_SEQ_DIV0_EN
    chk("rst_div0", {7'd0, DIV0}, 8'd0);
`endif

    // CE low in IDLE drops S_READY.
    @(negedge CLK); CE = 1'b0; #1;
    chk("ce_low_s_ready", {7'd0, S_READY}, 8'd0);
    CE = 1'b1;

    full_op(8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, "p100_p7");
    full_op(8'h9C,  8'd7,  8'hF2, 8'hFE, 1'b0, "m100_p7");
    full_op(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, "p100_m7");
    full_op(8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, "m128_m1");
    full_op(8'hFB,  8'h00, 8'hFF, 8'hFB, 1'b1, "m5_z");
    full_op(8'h05,  8'h00, 8'hFF, 8'h05, 1'b1, "p5_z");
    full_op(8'h80,  8'h03, 8'hD6, 8'hFE, 1'b0, "m128_p3");

    // Backpressure: hold M_READY low 5 cycles in DONE while new operands are offered.
    accept(8'd50, 8'd6, "stall");
    wait_valid(cyc);
    chk("stall_latency", 8'(cyc), 8'd10);
    S_VALID = 1'b1; A = 8'd1; B = 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check_result("stall_hold", 8'h08, 8'h02, 1'b0);
      chk("stall_s_ready", {7'd0, S_READY}, 8'd0);
    end
    S_VALID = 1'b0;
    complete("stall");
    @(negedge CLK);
    chk("stall_single_xfer", {7'd0, M_VALID}, 8'd0);
    chk("stall_idle", {7'd0, S_READY}, 8'd1);

    // CE low for 3 cycles mid-calculation delays the result by exactly 3 cycles.
    accept(8'd77, 8'hF8, "ce");
    repeat (3) @(posedge CLK);
    #1 CE = 1'b0;
    repeat (3) @(posedge CLK);
    #1 CE = 1'b1;
    cyc = 7;
    while (M_VALID !== 1'b1 && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
    end
    chk("ce_latency", 8'(cyc), 8'd13);
    check_result("ce", 8'hF7, 8'h05, 1'b0);
    complete("ce");

    // Reset in the middle of CALC aborts the operation.
    accept(8'd100, 8'd7, "abort");
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    chk("abort_s_ready", {7'd0, S_READY}, 8'd1);
    chk("abort_q", Q, 8'h00);
    chk("abort_r", R, 8'h00);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge CLK); #1;
        if (M_VALID === 1'b1) seen = 1'b1;
      end
      chk("abort_no_valid", {7'd0, seen}, 8'd0);
    end
    full_op(8'd9, 8'd3, 8'h03, 8'h00, 1'b0, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
